// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int SERIAL_SUB_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-index counter width; at least one bit so the counter always exists.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, diff = A - B - bin, one bit per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SERIAL_SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, diff_reg;
  logic [CW-1:0]    cnt_reg;
  logic             borrow_reg, bout_reg;
  logic             fs_a, fs_b, fs_d, fs_bout;
  logic             accept, last_bit;

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign accept    = in_valid && in_ready;
  assign last_bit  = (state_reg == RUN) && (cnt_reg == LAST);
  assign diff      = diff_reg;
  assign bout      = bout_reg;

  // One shared cell, steered to the current bit of the latched operands.
  assign fs_a = a_reg[cnt_reg];
  assign fs_b = b_reg[cnt_reg];

  full_subtractor u_fs (
    .a    (fs_a),
    .b    (fs_b),
    .bin  (borrow_reg),
    .d    (fs_d),
    .bout (fs_bout)
  );

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (cnt_reg == LAST) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      diff_reg   <= '0;
      cnt_reg    <= '0;
      borrow_reg <= 1'b0;
      bout_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        a_reg      <= A;
        b_reg      <= B;
        borrow_reg <= bin;
        cnt_reg    <= '0;
        diff_reg   <= '0;
        bout_reg   <= 1'b0;
      end else if (state_reg == RUN) begin
        diff_reg[cnt_reg] <= fs_d;
        borrow_reg        <= fs_bout;
        // Hold the counter at the last index rather than wrapping.
        if (!last_bit) cnt_reg <= cnt_reg + 1'b1;
        if (last_bit) bout_reg <= fs_bout;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_reg;

  assign ovf = ovf_reg;

  // Operand signs differ and the new result MSB disagrees with A's sign.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (accept) begin
      ovf_reg <= 1'b0;
    end else if (last_bit) begin
      ovf_reg <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (fs_d != a_reg[WIDTH-1]);
    end
  end
`endif

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Multi-cycle, bit-serial subtractor computing `diff = A - B - bin` one bit per clock, LSB first, with a ready/valid handshake on both input and output. It is the inverse arithmetic counterpart of the team's adder datapath and sits in the same arithmetic library. It trades latency for area: a single full-subtractor cell is reused for every bit position.

## Interface
Parameters:
- `WIDTH`, default 4: operand and result width in bits; must be ≥ 2.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in_valid`, input, 1: operands present.
- `in_ready`, output, 1: block can accept operands.
- `A`, input, `WIDTH`: minuend.
- `B`, input, `WIDTH`: subtrahend.
- `bin`, input, 1: borrow-in.
- `out_valid`, output, 1: result present.
- `out_ready`, input, 1: consumer accepts the result.
- `diff`, output, `WIDTH`: difference, modulo 2^`WIDTH`.
- `bout`, output, 1: borrow-out. It is 1 iff `A < B + bin` as unsigned values.
- `ovf`, output, 1: signed overflow. Present only under `SERIAL_SUB_OVF_EN`.

## Operation
- States: `IDLE`, `RUN`, `DONE`.
- `IDLE`:
  - `in_ready` = 1.
  - On `in_valid && in_ready`: latch `A`, `B`, load `borrow <= bin`, `cnt <= 0`, clear `diff` to 0, then go to `RUN`.
- `RUN`:
  - Each cycle, bit i = `cnt`:
    - `diff[i] <= A[i] ^ B[i] ^ borrow`.
    - `borrow <= (~A[i] & B[i]) | (~(A[i] ^ B[i]) & borrow)`.
    - `cnt <= cnt + 1`.
  - On the cycle processing i = `WIDTH-1`, go to `DONE`.
- `DONE`:
  - `out_valid` = 1; `bout` = final `borrow`.
  - `diff`, `bout` and `ovf` stay stable until `out_valid && out_ready`, then go to `IDLE`.
- `in_ready` = 0 in `RUN` and `DONE`. Input changes are ignored outside the accept cycle.
- `in_valid` must not wait for `in_ready`. `out_valid` never deasserts without a handshake.
- `cnt` width is `$clog2(WIDTH)`; it never wraps past `WIDTH-1`.
- Reset values: state `IDLE`, `in_ready` 1 (combinational from state), `out_valid` 0, `diff` 0, `bout` 0, `ovf` 0, `cnt` 0, `borrow` 0.
- Reset asserted mid-`RUN` or mid-`DONE` aborts the operation and discards the result. The first accept after reset behaves like a fresh start.
- `out_ready` held high continuously: result is consumed in its first `DONE` cycle.

## Timing
- The accept edge is edge 0. Bits 0..`WIDTH-1` are written on edges 1..`WIDTH`.
- `out_valid` rises after edge `WIDTH`, giving a latency of `WIDTH` cycles from accept.
- The handshake edge returns the block to `IDLE`. The next accept can occur one edge later.
- Throughput is one operation per `WIDTH+2` cycles when `in_valid` and `out_ready` are held high.
- All outputs are registered or decoded from state only. There is no combinational path from `A`/`B` to any output.

## Configuration
- `SERIAL_SUB_OVF_EN` defined:
  - Port `ovf` exists.
  - It is registered on the final `RUN` edge as `(A[WIDTH-1] != B[WIDTH-1]) && (diff_msb_new != A[WIDTH-1])`, treating operands as two's complement and ignoring `bin`'s sign.
  - It is held with `diff` and reset to 0.
- `SERIAL_SUB_OVF_EN` undefined: the port and its register are absent. All other behaviour is identical.

## Structure
- Shared package `serial_sub_pkg` contains:
  - The state enum (`IDLE`, `RUN`, `DONE`).
  - The default-width constant `SERIAL_SUB_WIDTH_DEF = 4`.
  - A function returning the counter width for a given `WIDTH`.
- One sub-module, `full_subtractor` (`a`, `b`, `bin` → `d`, `bout`), is instantiated once and fed bit `cnt` of the latched operands.

## Test plan
Default `WIDTH` = 4 unless noted.
- Accept `A`=9, `B`=3, `bin`=0 → after 4 cycles `out_valid`=1, `diff`=6, `bout`=0.
- `A`=3, `B`=9, `bin`=0 → `diff`=0xA, `bout`=1. `A`=0, `B`=0, `bin`=1 → `diff`=0xF, `bout`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles in `DONE` → `out_valid` and `diff` stable. `in_ready` stays 0 and `in_valid` pulses are ignored. Raising `out_ready` gives exactly one transfer.
- Assert `rst_n`=0 asynchronously after 2 `RUN` cycles → next edge-independent outputs are 0 and state is `IDLE`. A new op with 5-5 → `diff`=0, `bout`=0.
- With `SERIAL_SUB_OVF_EN`: 7-0xF (7-(-1)) → `diff`=8, `ovf`=1. 8-1 → `diff`=7, `ovf`=1. 5-2 → `ovf`=0.
- `WIDTH`=8, randomized back-to-back ops with `out_ready` toggled randomly → every `diff`/`bout` matches `{bout,diff} = A - B - bin` and latency is exactly 8 cycles.
